div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DIVZ_RESULT, default 64'h0: the {remainder, quotient} value returned for a zero divisor.
REQ-002 SHALL have clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1: reset, synchronous and active-high (RstEnable = 1'b1).
REQ-004 SHALL have signed_div_i  input  1: 1 = DIV (two's-complement operands), 0 = DIVU.
REQ-005 SHALL have opdata1_i  input  32: the dividend.
REQ-006 SHALL have opdata2_i  input  32: the divisor.
REQ-007 SHALL have start_i  input  1: EX stage requests a divide, held high until ready_o is seen.
REQ-008 SHALL have annul_i  input  1: the pipeline is flushing and the operation in flight must be abandoned.
REQ-009 SHALL have result_o  output  64: {remainder[63:32], quotient[31:0]}, for writing HI and LO.
REQ-010 SHALL have ready_o  output  1: result_o is valid.
REQ-011 SHALL have stallreq_o  output  1: a combinational request to stall the pipeline.

Function
REQ-012 SHALL implement four states: IDLE, DIVZERO, BUSY and DONE.
REQ-013 IDLE, when start_i=1 and annul_i=0: if opdata2_i=0, go to DIVZERO; otherwise go to BUSY with cnt=0.
REQ-014 On leaving IDLE, SHALL latch the absolute values of the operands; absolute values apply only when signed_div_i=1 and bit31=1, otherwise operands are used raw.
REQ-015 On leaving IDLE, SHALL latch signed_div_i, the sign of the quotient (opdata1_i[31]^opdata2_i[31]) and the sign of the remainder (opdata1_i[31]).
REQ-016 Input changes after the latch SHALL be ignored until the state returns to IDLE.
REQ-017 BUSY, while cnt<32: one restoring shift-subtract step per cycle; the 33-bit trial difference decides the quotient bit; cnt increments by 1.
REQ-018 BUSY, at cnt=32: apply sign correction to quotient and remainder if latched signed, then go to DONE.
REQ-019 In any cycle, annul_i=1 in BUSY or DIVZERO SHALL force IDLE with cnt=0, and no ready_o pulse SHALL follow.
REQ-020 DIVZERO SHALL go to DONE on the next edge with result_o=DIVZ_RESULT.
REQ-021 DONE SHALL drive ready_o=1 and hold result_o stable.
REQ-022 DONE with start_i=0 SHALL go to IDLE, with ready_o=0 and result_o=0.
REQ-023 DONE with start_i=1 SHALL remain in DONE and SHALL NOT restart a divide.
REQ-024 ready_o and result_o SHALL be registered; result_o SHALL be 0 in every state other than DONE.
REQ-025 Latency, divisor nonzero: start sampled at edge N, then IDLE->BUSY at N, 32 iterations at N+1..N+32, finalize and enter DONE at N+33, ready_o=1 after edge N+33.
REQ-026 Latency, divisor zero: DIVZERO at N, DONE at N+1, ready_o=1 after edge N+1.
REQ-027 stallreq_o SHALL equal start_i & ~annul_i & ~ready_o, so the pipeline is released in the cycle ready_o is high.
REQ-028 Signed remainder SHALL carry the sign of the dividend; signed quotient SHALL truncate toward zero.
REQ-029 All arithmetic SHALL be modulo 2^32 per half; 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000, remainder 0, with no exception raised.
REQ-030 start_i=1 together with annul_i=1 in IDLE SHALL leave the block in IDLE.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, cnt=0, ready_o=0, result_o=64'h0 and all latched operands to 0, overriding every other input.
REQ-032 rst=1 mid-BUSY SHALL abandon the operation; the first start_i after rst is released SHALL begin a fresh divide.

Verification
REQ-033 Unsigned: opdata1=0xFFFFFFFF, opdata2=0x10, signed=0, start held -> ready_o rises 34 edges after the start edge; result_o = {0x0000000F, 0x0FFFFFFF}; stallreq_o=1 until that cycle.
REQ-034 Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2, signed=1 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; also -8 / -2 -> {0x00000000, 0x00000004}.
REQ-035 Divisor zero: opdata1=0x1234, opdata2=0 -> ready_o=1 two edges after start with result_o=DIVZ_RESULT; start_i dropped -> ready_o=0 on the next edge.
REQ-036 Overflow case: 0x80000000 / 0xFFFFFFFF signed -> result_o = {0x00000000, 0x80000000}.
REQ-037 Annul: annul_i=1 at iteration cnt=10 -> IDLE next edge; no ready_o pulse; a new divide of 100/7 started afterward -> {0x2, 0xE}.
REQ-038 Reset: rst=1 during BUSY with start_i held -> outputs 0 on the next edge; after rst is released the divide restarts and completes 34 edges later.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle 32-bit restoring divider for the EX stage.
// Produces {remainder, quotient} for HI/LO, with signed (DIV) and unsigned (DIVU) modes,
// a fixed result for a zero divisor, and pipeline annul/stall handshaking.
module div_ctrl #(
    parameter logic [63:0] DIVZ_RESULT = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {StIdle, StDivZero, StBusy, StDone} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;      // partial remainder
    logic [31:0] quo_q;      // dividend bits shift out of the top, quotient bits shift in
    logic [31:0] dvsr_q;     // divisor magnitude
    logic        signed_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    // Operand magnitudes, one restoring step, and final sign correction
    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        shifted = {rem_q, quo_q[31]};
        // trial[32] set means the shifted remainder is smaller than the divisor
        trial   = shifted - {1'b0, dvsr_q};
        quo_fin = (signed_q && neg_quo_q) ? (~quo_q + 32'd1) : quo_q;
        rem_fin = (signed_q && neg_rem_q) ? (~rem_q + 32'd1) : rem_q;
    end

    // Stall the pipeline while a request is pending and no result is ready
    assign stallreq_o = start_i & ~annul_i & ~ready_o;

    // Divider state machine with registered result and ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= 64'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'h0;
                    if (start_i && !annul_i) begin
                        rem_q     <= 32'd0;
                        quo_q     <= op1_abs;
                        dvsr_q    <= op2_abs;
                        signed_q  <= signed_div_i;
                        neg_quo_q <= opdata1_i[31] ^ opdata2_i[31];
                        neg_rem_q <= opdata1_i[31];
                        cnt_q     <= 6'd0;
                        state_q   <= (opdata2_i == 32'd0) ? StDivZero : StBusy;
                    end
                end
                StDivZero: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                        cnt_q   <= 6'd0;
                    end else begin
                        state_q  <= StDone;
                        ready_o  <= 1'b1;
                        result_o <= DIVZ_RESULT;
                    end
                end
                StBusy: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                        cnt_q   <= 6'd0;
                    end else if (cnt_q != 6'd32) begin
                        if (trial[32]) begin
                            rem_q <= shifted[31:0];
                            quo_q <= {quo_q[30:0], 1'b0};
                        end else begin
                            rem_q <= trial[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        result_o <= {rem_fin, quo_fin};
                        ready_o  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // Hold the result until EX drops its request; never restart from here
                    if (!start_i) begin
                        state_q  <= StIdle;
                        cnt_q    <= 6'd0;
                        ready_o  <= 1'b0;
                        result_o <= 64'h0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
